// File: rtl/gomoku_game_ctrl_if.sv
// gomoku_game_ctrl_if: button pulses in, board/cursor/timer/status out.
//   master: button driver side (drives btn_*, observes board and status)
//   slave : game controller side (samples btn_*, drives map/map_w/x_index/y_index/num/state/turn_w/busy)
interface gomoku_game_ctrl_if;
  logic btn_up, btn_down, btn_left, btn_right, btn_place, btn_start, btn_undo;
  logic [360:0] map, map_w;
  logic [4:0] x_index, y_index, num;
  logic [1:0] state;
  logic turn_w, busy;
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, btn_start, btn_undo,
    input  map, map_w, x_index, y_index, num, state, turn_w, busy
  );
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, btn_start, btn_undo,
    output map, map_w, x_index, y_index, num, state, turn_w, busy
  );
endinterface

// File: rtl/gomoku_game_ctrl.sv
// gomoku_game_ctrl: 19x19 gomoku sequencer with cursor, turn timer and serial five-in-a-row check.
//   clk, rst_sys_n (async active-low); io (slave): btn_* pulses in; map/map_w (bit y*19+x),
//   x_index/y_index cursor, num seconds left, state 00 IDLE/01 PLAY/10 BLACK_WIN/11 WHITE_WIN,
//   turn_w, busy. Define GOMOKU_UNDO_EN for one-level undo of the last placed stone.
module gomoku_game_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TURN_SEC = 15
) (
  input  logic clk,
  input  logic rst_sys_n,
  gomoku_game_ctrl_if.slave io
);
  typedef enum logic [2:0] {IDLE, PLAY, CHECK, BWIN, WWIN} state_t;
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(TICK_DIV - 1);
  localparam logic [4:0] RELOAD = 5'(TURN_SEC);
  state_t st, st_nx;
  logic [360:0] bmap, wmap;
  logic [4:0] x, y, num, px, py, wx, wy;
  logic [DW-1:0] div;
  logic [8:0] moves, cur_idx, walk_idx;
  logic [1:0] dir, run;
  logic [3:0] cnt, cnt_nx;
  logic neg, turn_w;
  logic signed [5:0] dx, dy, cx, cy;
  logic in_board, hit, walk_end, dir_end, five, occupied, place_ok, tick;
`ifdef GOMOKU_UNDO_EN
  logic [8:0] last_idx;
  logic last_w, can_undo, undo;
  assign undo = st == PLAY && io.btn_undo && can_undo && moves != 9'd0 && !place_ok;
`else
  logic unused_undo;
  assign unused_undo = io.btn_undo;
`endif
  // The walk head (wx,wy) is the last matching cell; each CHECK cycle probes one step further.
  // run counts matches on the current walk, so a hit with run==3 is the 4th and ends the walk.
  always_comb begin
    dx = (dir == 2'd1) ? 6'sd0 : 6'sd1;
    dy = (dir == 2'd0) ? 6'sd0 : (dir == 2'd3) ? -6'sd1 : 6'sd1;
    cx = $signed({1'b0, wx}) + (neg ? -dx : dx);
    cy = $signed({1'b0, wy}) + (neg ? -dy : dy);
    in_board = !cx[5] && !cy[5] && cx <= 6'sd18 && cy <= 6'sd18;
    walk_idx = 9'(cy[4:0]) * 9'd19 + 9'(cx[4:0]);
    hit = in_board && (turn_w ? wmap[walk_idx] : bmap[walk_idx]);
    walk_end = !hit || run == 2'd3;
    cnt_nx = cnt + {3'd0, hit};
    dir_end = st == CHECK && walk_end && neg;
    five = cnt_nx >= 4'd5;
    cur_idx = 9'(y) * 9'd19 + 9'(x);
    occupied = bmap[cur_idx] || wmap[cur_idx];
    place_ok = st == PLAY && io.btn_place && !occupied;
    tick = st == PLAY && div == DIV_TOP;
    st_nx = st;
    if (io.btn_start) st_nx = PLAY;
    else if (place_ok) st_nx = CHECK;
    else if (dir_end)
      st_nx = five ? (turn_w ? WWIN : BWIN) : (dir != 2'd3) ? CHECK : (moves == 9'd361) ? IDLE : PLAY;
  end
  always_ff @(posedge clk or negedge rst_sys_n)
    if (!rst_sys_n) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      bmap <= '0;
      wmap <= '0;
      x <= 5'd9;
      y <= 5'd9;
      num <= RELOAD;
      turn_w <= 1'b0;
      moves <= '0;
      div <= '0;
      px <= '0;
      py <= '0;
      wx <= '0;
      wy <= '0;
      dir <= '0;
      neg <= 1'b0;
      run <= '0;
      cnt <= '0;
`ifdef GOMOKU_UNDO_EN
      last_idx <= '0;
      last_w <= 1'b0;
      can_undo <= 1'b0;
`endif
    end else if (io.btn_start) begin
      bmap <= '0;
      wmap <= '0;
      x <= 5'd9;
      y <= 5'd9;
      num <= RELOAD;
      turn_w <= 1'b0;
      moves <= '0;
      div <= '0;
`ifdef GOMOKU_UNDO_EN
      can_undo <= 1'b0;
`endif
    end else begin
      if (st == PLAY) begin
        if (io.btn_up != io.btn_down)
          y <= io.btn_up ? y - {4'd0, y != 5'd0} : y + {4'd0, y != 5'd18};
        if (io.btn_left != io.btn_right)
          x <= io.btn_left ? x - {4'd0, x != 5'd0} : x + {4'd0, x != 5'd18};
      end
      if (place_ok) begin
        if (turn_w) wmap[cur_idx] <= 1'b1;
        else bmap[cur_idx] <= 1'b1;
        moves <= moves + 9'd1;
        px <= x;
        py <= y;
        wx <= x;
        wy <= y;
        dir <= '0;
        neg <= 1'b0;
        run <= '0;
        cnt <= 4'd1;
        div <= '0;
`ifdef GOMOKU_UNDO_EN
        last_idx <= cur_idx;
        last_w <= turn_w;
        can_undo <= 1'b1;
      end else if (undo) begin
        if (last_w) wmap[last_idx] <= 1'b0;
        else bmap[last_idx] <= 1'b0;
        moves <= moves - 9'd1;
        turn_w <= last_w;
        num <= RELOAD;
        div <= '0;
        can_undo <= 1'b0;
`endif
      end else if (st == PLAY) begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) begin
          num <= (num == 5'd0) ? RELOAD : num - 5'd1;
          if (num == 5'd0) turn_w <= ~turn_w;
        end
      end
      if (st == CHECK) begin
        if (!walk_end) begin
          wx <= cx[4:0];
          wy <= cy[4:0];
          run <= run + 2'd1;
          cnt <= cnt_nx;
        end else begin
          wx <= px;
          wy <= py;
          run <= '0;
          neg <= ~neg;
          dir <= dir + {1'b0, neg};
          cnt <= neg ? 4'd1 : cnt_nx;
        end
        if (dir_end && !five && dir == 2'd3) begin
          turn_w <= ~turn_w;
          num <= RELOAD;
          div <= '0;
        end
      end
    end
  end
  assign io.map = bmap;
  assign io.map_w = wmap;
  assign io.x_index = x;
  assign io.y_index = y;
  assign io.num = num;
  assign io.turn_w = turn_w;
  assign io.busy = st == CHECK;
  assign io.state = (st == IDLE) ? 2'b00 : (st == BWIN) ? 2'b10 : (st == WWIN) ? 2'b11 : 2'b01;
endmodule

// File: tb/tb_gomoku_game_ctrl.sv
// tb_gomoku_game_ctrl: randomized and directed checks of gomoku_game_ctrl against a board-level model.
module tb_gomoku_game_ctrl;
  localparam int TD = 4;
  localparam int TS = 15;
  logic clk = 1'b0;
  logic rst_sys_n = 1'b0;
  gomoku_game_ctrl_if io();
  gomoku_game_ctrl #(.TICK_DIV(TD), .TURN_SEC(TS)) dut (.clk(clk), .rst_sys_n(rst_sys_n), .io(io));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  // model: bd 0 empty/1 black/2 white; mph 0 idle,1 play,2 checking,3 black won,4 white won
  int bd[19][19];
  int mx, my, mnum, mturn, mcnt, mmoves, mph, pend, lx, ly, lc;
  bit lok;
  int ddx[4] = '{1, 0, 1, 1};
  int ddy[4] = '{0, 1, 1, -1};

  function automatic logic [360:0] map_of(input int c);
    logic [360:0] m;
    for (int i = 0; i < 361; i++) m[i] = (bd[i / 19][i % 19] == c);
    return m;
  endfunction

  function automatic int run_len(input int x, input int y, input int dx, input int dy, input int c);
    int n, cx, cy;
    n = 0;
    cx = x + dx;
    cy = y + dy;
    while (n < 4 && cx >= 0 && cx <= 18 && cy >= 0 && cy <= 18 && bd[cy][cx] == c) begin
      n++;
      cx += dx;
      cy += dy;
    end
    return n;
  endfunction

  function automatic bit wins(input int x, input int y, input int c);
    for (int d = 0; d < 4; d++)
      if (1 + run_len(x, y, ddx[d], ddy[d], c) + run_len(x, y, -ddx[d], -ddy[d], c) >= 5) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_state();
    return (mph == 0) ? 2'b00 : (mph == 3) ? 2'b10 : (mph == 4) ? 2'b11 : 2'b01;
  endfunction

  task automatic mreset();
    foreach (bd[i, j]) bd[i][j] = 0;
    mx = 9; my = 9; mnum = TS; mturn = 0; mcnt = 0; mmoves = 0; mph = 0; lok = 0; pend = 1;
  endtask

  task automatic cyc(input bit up, input bit dn, input bit lf, input bit rt, input bit pl, input bit s, input bit un);
    bit was_play;
    io.btn_up = up; io.btn_down = dn; io.btn_left = lf; io.btn_right = rt;
    io.btn_place = pl; io.btn_start = s; io.btn_undo = un;
    was_play = (mph == 1);
    if (s) begin
      mreset();
      mph = 1;
    end else if (was_play) begin
      if (pl && bd[my][mx] == 0) begin
        bd[my][mx] = mturn + 1;
        mmoves++;
        lx = mx; ly = my; lc = mturn; lok = 1;
        mph = 2;
        pend = wins(mx, my, mturn + 1) ? 3 + mturn : (mmoves == 361) ? 0 : 1;
      end
`ifdef GOMOKU_UNDO_EN
      else if (un && lok && mmoves > 0) begin
        bd[ly][lx] = 0; mmoves--; mturn = lc; mnum = TS; mcnt = 0; lok = 0;
      end
`endif
      else begin
        mcnt++;
        if (mcnt == TD) begin
          mcnt = 0;
          if (mnum == 0) begin mturn ^= 1; mnum = TS; end
          else mnum--;
        end
      end
      if (up != dn) my = up ? (my > 0 ? my - 1 : 0) : (my < 18 ? my + 1 : 18);
      if (lf != rt) mx = lf ? (mx > 0 ? mx - 1 : 0) : (mx < 18 ? mx + 1 : 18);
    end
    @(posedge clk);
    #1;
    io.btn_up = 0; io.btn_down = 0; io.btn_left = 0; io.btn_right = 0;
    io.btn_place = 0; io.btn_start = 0; io.btn_undo = 0;
  endtask

  task automatic resolve();
    if (pend == 1) begin
      mph = 1; mturn ^= 1; mnum = TS; mcnt = 0;
    end else mph = pend;
  endtask

  task automatic wait_check(output int lat);
    lat = 1;
    while (io.busy === 1'b1 && lat < 40) begin
      cyc($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, 1'b0, $urandom % 2);
      lat++;
    end
    resolve();
  endtask

  task automatic move_to(input int tx, input int ty);
    for (int i = 0; i < 40 && (mx != tx || my != ty); i++)
      cyc(my > ty, my < ty, mx > tx, mx < tx, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    io.btn_up = 0; io.btn_down = 0; io.btn_left = 0; io.btn_right = 0;
    io.btn_place = 0; io.btn_start = 0; io.btn_undo = 0;
    mreset();
    #12;
    checks++; if (io.map !== '0 || io.map_w !== '0) begin failures++; $display("FAIL reset_maps: got %0h/%0h want 0/0", io.map, io.map_w); end
    checks++; if (io.x_index !== 5'd9 || io.y_index !== 5'd9) begin failures++; $display("FAIL reset_cursor: got %0d,%0d want 9,9", io.x_index, io.y_index); end
    checks++; if (io.num !== 5'd15) begin failures++; $display("FAIL reset_num: got %0d want 15", io.num); end
    checks++; if (io.state !== 2'b00 || io.turn_w !== 1'b0 || io.busy !== 1'b0) begin failures++; $display("FAIL reset_status: got state=%b turn_w=%b busy=%b want 00 0 0", io.state, io.turn_w, io.busy); end
    @(posedge clk);
    #1 rst_sys_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (io.state !== 2'b00) begin failures++; $display("FAIL idle_hold: got state=%b want 00", io.state); end
  endtask

  task automatic test_start_cursor();
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++; if (io.state !== 2'b01 || io.x_index !== 5'd9 || io.y_index !== 5'd9 || io.num !== 5'd15 || io.turn_w !== 1'b0)
      begin failures++; $display("FAIL start: got state=%b x=%0d y=%0d num=%0d turn_w=%b want 01 9 9 15 0", io.state, io.x_index, io.y_index, io.num, io.turn_w); end
    repeat (20) cyc(0, 0, 1, 0, 0, 0, 0);
    checks++; if (io.x_index !== 5'd0 || io.y_index !== 5'd9) begin failures++; $display("FAIL left_saturate: got x=%0d y=%0d want 0 9", io.x_index, io.y_index); end
    repeat (12) cyc(1, 0, 0, 1, 0, 0, 0);
    checks++; if (io.x_index !== 5'd12 || io.y_index !== 5'd0) begin failures++; $display("FAIL diag_saturate: got x=%0d y=%0d want 12 0", io.x_index, io.y_index); end
  endtask

  task automatic test_win();
    int lat, tx, ty;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      tx = 5 + i / 2;
      ty = (i % 2) ? 6 : 5;
      move_to(tx, ty);
      cyc(0, 0, 0, 0, 1, 0, 0);
      checks++; if (io.busy !== 1'b1) begin failures++; $display("FAIL win_busy_%0d: got %b want 1", i, io.busy); end
      wait_check(lat);
      checks++; if (lat > 33 || io.busy !== 1'b0) begin failures++; $display("FAIL win_latency_%0d: got %0d clk busy=%b want <=33 busy=0", i, lat, io.busy); end
    end
    checks++; if (io.state !== 2'b10) begin failures++; $display("FAIL black_win_state: got %b want 10", io.state); end
    checks++; if (io.map[104:100] !== 5'b11111) begin failures++; $display("FAIL black_row: got %b want 11111", io.map[104:100]); end
    checks++; if (io.map !== map_of(1) || io.map_w !== map_of(2)) begin failures++; $display("FAIL win_maps: got %0h/%0h want %0h/%0h", io.map, io.map_w, map_of(1), map_of(2)); end
    cyc(0, 0, 1, 0, 1, 0, 0);
    checks++; if (io.x_index !== 5'd9 || io.map !== map_of(1)) begin failures++; $display("FAIL win_frozen: got x=%0d want 9 and unchanged map", io.x_index); end
  endtask

  task automatic test_timer();
    int e;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      repeat (TD) cyc(0, 0, 0, 0, 0, 0, 0);
      e = 15 - k;
      checks++; if (io.num !== e[4:0] || io.turn_w !== 1'b0) begin failures++; $display("FAIL timer_%0d: got num=%0d turn_w=%b want %0d 0", k, io.num, io.turn_w, e); end
    end
    repeat (TD) cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (io.turn_w !== 1'b1 || io.num !== 5'd15) begin failures++; $display("FAIL timer_expire: got turn_w=%b num=%0d want 1 15", io.turn_w, io.num); end
  endtask

  task automatic test_occupied();
    int lat;
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    wait_check(lat);
    checks++; if (io.turn_w !== 1'b1 || io.map[180] !== 1'b1) begin failures++; $display("FAIL first_place: got turn_w=%b map180=%b want 1 1", io.turn_w, io.map[180]); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++; if (io.map !== map_of(1) || io.map_w !== '0) begin failures++; $display("FAIL occupied_maps: got %0h/%0h want %0h/0", io.map, io.map_w, map_of(1)); end
    checks++; if (io.turn_w !== 1'b1 || io.busy !== 1'b0) begin failures++; $display("FAIL occupied_status: got turn_w=%b busy=%b want 1 0", io.turn_w, io.busy); end
  endtask

  task automatic test_opposing();
    cyc(0, 0, 0, 0, 0, 1, 0);
    move_to(18, 9);
    cyc(1, 1, 0, 1, 0, 0, 0);
    checks++; if (io.x_index !== 5'd18 || io.y_index !== 5'd9) begin failures++; $display("FAIL opposing: got x=%0d y=%0d want 18 9", io.x_index, io.y_index); end
    cyc(0, 1, 1, 1, 0, 0, 0);
    checks++; if (io.x_index !== 5'd18 || io.y_index !== 5'd10) begin failures++; $display("FAIL opposing_x: got x=%0d y=%0d want 18 10", io.x_index, io.y_index); end
  endtask

  task automatic test_place_vs_expiry();
    int lat;
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (15 * TD + TD - 1) cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (io.num !== 5'd0 || io.turn_w !== 1'b0) begin failures++; $display("FAIL pre_expiry: got num=%0d turn_w=%b want 0 0", io.num, io.turn_w); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++; if (io.map[180] !== 1'b1 || io.busy !== 1'b1) begin failures++; $display("FAIL place_wins: got map180=%b busy=%b want 1 1", io.map[180], io.busy); end
    wait_check(lat);
    checks++; if (io.turn_w !== 1'b1 || io.num !== 5'd15 || io.state !== 2'b01) begin failures++; $display("FAIL after_place_expiry: got turn_w=%b num=%0d state=%b want 1 15 01", io.turn_w, io.num, io.state); end
  endtask

  task automatic test_undo();
    int lat;
    cyc(0, 0, 0, 0, 0, 1, 0);
    move_to(3, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    wait_check(lat);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
`ifdef GOMOKU_UNDO_EN
    checks++; if (io.map[60] !== 1'b0 || io.turn_w !== 1'b0 || io.num !== 5'd15) begin failures++; $display("FAIL undo: got map60=%b turn_w=%b num=%0d want 0 0 15", io.map[60], io.turn_w, io.num); end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++; if (io.map !== '0 || io.map_w !== '0 || io.turn_w !== 1'b0) begin failures++; $display("FAIL undo_twice: got map=%0h turn_w=%b want 0 0", io.map, io.turn_w); end
`else
    checks++; if (io.map[60] !== 1'b1 || io.turn_w !== 1'b1) begin failures++; $display("FAIL undo_ignored: got map60=%b turn_w=%b want 1 1", io.map[60], io.turn_w); end
`endif
    checks++; if (io.map !== map_of(1) || io.turn_w !== mturn[0] || io.num !== mnum[4:0]) begin failures++; $display("FAIL undo_model: got turn_w=%b num=%0d want %0d %0d", io.turn_w, io.num, mturn, mnum); end
  endtask

  task automatic test_reset_midcheck();
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2 rst_sys_n = 1'b0;
    #2;
    mreset();
    checks++; if (io.busy !== 1'b0 || io.state !== 2'b00 || io.map !== '0 || io.x_index !== 5'd9 || io.num !== 5'd15 || io.turn_w !== 1'b0)
      begin failures++; $display("FAIL reset_midcheck: got busy=%b state=%b x=%0d num=%0d turn_w=%b want 0 00 9 15 0", io.busy, io.state, io.x_index, io.num, io.turn_w); end
    @(posedge clk);
    #1 rst_sys_n = 1'b1;
  endtask

  task automatic test_random();
    int lat;
    bit s;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 1200; i++) begin
      s = (mph != 1) ? ($urandom % 8 == 0) : ($urandom % 400 == 0);
      cyc($urandom % 3 == 0, $urandom % 3 == 0, $urandom % 3 == 0, $urandom % 3 == 0, $urandom % 5 == 0, s, $urandom % 10 == 0);
      if (mph == 2) begin
        checks++; if (io.busy !== 1'b1) begin failures++; $display("FAIL rnd_busy@%0d: got %b want 1", i, io.busy); end
        wait_check(lat);
        checks++; if (lat > 33) begin failures++; $display("FAIL rnd_latency@%0d: got %0d want <=33", i, lat); end
      end
      checks++; if (io.x_index !== mx[4:0] || io.y_index !== my[4:0]) begin failures++; $display("FAIL rnd_cursor@%0d: got %0d,%0d want %0d,%0d", i, io.x_index, io.y_index, mx, my); end
      checks++; if (io.num !== mnum[4:0] || io.turn_w !== mturn[0]) begin failures++; $display("FAIL rnd_timer@%0d: got num=%0d turn_w=%b want %0d %0d", i, io.num, io.turn_w, mnum, mturn); end
      checks++; if (io.state !== exp_state() || io.busy !== 1'b0) begin failures++; $display("FAIL rnd_state@%0d: got %b busy=%b want %b 0", i, io.state, io.busy, exp_state()); end
      checks++; if (io.map !== map_of(1) || io.map_w !== map_of(2)) begin failures++; $display("FAIL rnd_maps@%0d: got %0h/%0h want %0h/%0h", i, io.map, io.map_w, map_of(1), map_of(2)); end
    end
  endtask

  initial begin
    test_reset();
    test_start_cursor();
    test_win();
    test_timer();
    test_occupied();
    test_opposing();
    test_place_vs_expiry();
    test_undo();
    test_reset_midcheck();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
